hamming_scrub_ctrl: RTL and testbench
=====================================

Name: hamming_scrub_ctrl

Overview:
Controller that owns a Hamming(7,4)-protected counter register and sequences every access to it: increment, parity encode, periodic scrub check, and single-bit correction write-back. One FSM serialises requester increments, a scrub timer, and a debug error-injection port onto the shared encode/syndrome datapath. It is the sequencing layer above the counter/parity/syndrome datapath.

Parameters:
WIDTH, 16, counter width; must be a multiple of 4.
BLOCKS, WIDTH/4, number of 4-bit Hamming blocks.
PAR_BITS, BLOCKS*3, stored parity width (BLOCKS*4 with HAMMING_SECDED_EN).
SCRUB_PERIOD, 64, cycles between automatic scrubs; must be >= 4.
CNT_W, 8, width of the corrected-error counter.

Ports:
- The block has one clock. Reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inc_req  in  1  increment request; held high until inc_ack.
- inc_ack  out  1  one-cycle pulse; the increment has been accepted.
- scrub_req  in  1  forces a scrub; sticky internally until the scrub starts.
- inj_en  in  1  error-injection strobe.
- inj_data_mask  in  WIDTH  XOR mask applied to the counter register.
- inj_par_mask  in  PAR_BITS  XOR mask applied to the parity register.
- count  out  WIDTH  counter register value.
- parity  out  PAR_BITS  stored parity register.
- busy  out  1  high when state != IDLE.
- err_corrected  out  1  one-cycle pulse when a correction is written.
- err_block  out  BLOCKS  per-block mask of corrected blocks; valid with err_corrected, otherwise 0.
- corr_count  out  CNT_W  saturating count of corrections.
- uncorr_err  out  1  one-cycle pulse for an uncorrectable error; tied 0 without HAMMING_SECDED_EN.

Behaviour:
- Encoding per block i, with d = count[4i+3:4i]:
  - p2 = d0^d2^d3
  - p1 = d0^d1^d3
  - p0 = d0^d1^d2
  - stored at parity[3i+2:3i].
- Syndrome = stored parity ^ re-encoded parity, per block.
  - 111 -> flip d0; 011 -> flip d1; 101 -> flip d2; 110 -> flip d3.
  - 001, 010, 100 -> flip p0, p1, p2 respectively.
  - 000 -> no error.
- Reset values:
  - count = 0 and parity = 0 (a consistent codeword).
  - state = IDLE; timer = SCRUB_PERIOD-1; scrub pending cleared.
  - All pulse outputs, err_block and corr_count = 0.
- States: IDLE, INCR, ENCODE, CHECK, CORRECT.
- IDLE arbitration, highest priority first:
  1. inj_en: XOR both masks into the registers this cycle, remain IDLE.
  2. Scrub due (timer==0 or scrub pending): go to CHECK.
  3. inc_req: go to INCR.
  - inj_en outside IDLE is ignored.
- INCR: inc_ack=1; count <= count+1, mod 2^WIDTH (0xFFFF wraps to 0). Next state ENCODE.
- ENCODE: parity <= encode(count). Next state IDLE. Increment latency: accepted in IDLE at cycle t; ack at t+1; parity consistent at t+3.
- CHECK: register the syndrome; reload timer to SCRUB_PERIOD-1; clear scrub pending.
  - All blocks 000 -> IDLE.
  - Otherwise -> CORRECT.
- CORRECT: apply the per-block flips to count and parity.
  - err_corrected=1; err_block = blocks with nonzero syndrome.
  - corr_count += 1, saturating at all-ones.
  - Next state IDLE.
- Timer: decrements every cycle outside CHECK; saturates at 0.
- scrub_req in any state sets pending. A scrub_req arriving in the same cycle CHECK is entered is absorbed by that scrub.
- inc_req asserted during a scrub waits; inc_ack follows the return to IDLE.
- Reset mid-operation: immediate return to the reset values. An un-acked increment is lost; the requester keeps inc_req high and is served after reset.

Optional Feature:
HAMMING_SECDED_EN.
- Defined:
  - Each block adds bit p3 = XOR of d0..d3 and p0..p2; PAR_BITS = BLOCKS*4.
  - CHECK evaluates syndrome and overall mismatch per block:
    - syndrome != 0 with overall mismatch -> correct as above.
    - syndrome == 0 with overall mismatch -> flip p3 (counts as a correction).
    - syndrome != 0 with overall match -> uncorrectable: that block is left unchanged, uncorr_err pulses in CORRECT, and it is excluded from err_block.
- Undefined: 3-bit-per-block code, uncorr_err tied 0.

Decomposition:
- hamming_pkg holds:
  - The state enum.
  - BLOCK_DATA_W=4 and BLOCK_PAR_W (3 or 4).
  - Functions enc_block and correct_block.
- Sub-module hamming_block_codec: combinational encode/syndrome/corrected outputs for one block, instantiated BLOCKS times via generate.

Test Plan:
- Reset, then 5 increments with handshake -> count=0x0005, parity=0x002, each inc_ack exactly 1 cycle; busy high 2 cycles per increment.
- From count 0x0005, inj_data_mask=0x0004, then scrub_req:
  - Block-0 syndrome 101.
  - count returns to 0x0005.
  - err_corrected pulse with err_block=0001; corr_count=1.
- inj_par_mask=0x008, scrub -> parity restored to 0x002, count unchanged, err_block=0010, corr_count=2.
- Wrap: from count 0, inject data 0xFFFF with parity 0xFFF, then 1 increment -> count=0x0000, parity=0x000; a following scrub reports no error.
- No requests after reset -> CHECK entered at cycle 64; busy high for 1 cycle; no err_corrected.
- inc_req and scrub_req in the same IDLE cycle -> CHECK first, inc_ack afterwards.
- With HAMMING_SECDED_EN: 2-bit data mask 0x0003 -> uncorr_err pulse, count stays corrupted, corr_count unchanged.

Source files
------------

// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared types and helpers for the Hamming-protected scrub controller.
//   state_t        : controller FSM states
//   BLOCK_DATA_W   : data bits per code block (4)
//   BLOCK_PAR_W    : stored parity bits per block (3, or 4 with SECDED)
//   blk_fix_t      : result of correcting one block
//   enc_block      : parity for one 4-bit block
//   correct_block  : apply a registered syndrome/overall result to one block
// Optional feature macro: HAMMING_SECDED_EN (adds the overall parity bit p3).
// -----------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INCR    = 3'd1,
        ENCODE  = 3'd2,
        CHECK   = 3'd3,
        CORRECT = 3'd4
    } state_t;

    localparam int BLOCK_DATA_W = 4;
`ifdef HAMMING_SECDED_EN
    localparam int BLOCK_PAR_W  = 4;
`else
    localparam int BLOCK_PAR_W  = 3;
`endif

    typedef struct packed {
        logic [BLOCK_DATA_W-1:0] data;
        logic [BLOCK_PAR_W-1:0]  par;
`ifdef HAMMING_SECDED_EN
        logic                    uncorr;
`endif
        logic                    fixed;
    } blk_fix_t;

    // p0 = d0^d1^d2, p1 = d0^d1^d3, p2 = d0^d2^d3 (p3 = overall parity)
    function automatic logic [BLOCK_PAR_W-1:0] enc_block(input logic [BLOCK_DATA_W-1:0] d);
        logic [BLOCK_PAR_W-1:0] p;
        p[0] = d[0] ^ d[1] ^ d[2];
        p[1] = d[0] ^ d[1] ^ d[3];
        p[2] = d[0] ^ d[2] ^ d[3];
`ifdef HAMMING_SECDED_EN
        p[3] = (^d) ^ p[0] ^ p[1] ^ p[2];
`endif
        return p;
    endfunction

    // syn = stored ^ re-encoded parity {p2,p1,p0}.
    // ovr = overall mismatch; in the 3-bit code it is simply |syn, so a
    // nonzero syndrome always counts as a single correctable error.
    function automatic blk_fix_t correct_block(
        input logic [BLOCK_DATA_W-1:0] d,
        input logic [BLOCK_PAR_W-1:0]  p,
        input logic [2:0]              syn,
        input logic                    ovr
    );
        blk_fix_t r;
        r.data  = d;
        r.par   = p;
        r.fixed = 1'b0;
`ifdef HAMMING_SECDED_EN
        r.uncorr = 1'b0;
`endif
        if ((syn != 3'b000) && ovr) begin
            r.fixed = 1'b1;
            case (syn)
                3'b111:  r.data[0] = ~d[0];
                3'b011:  r.data[1] = ~d[1];
                3'b101:  r.data[2] = ~d[2];
                3'b110:  r.data[3] = ~d[3];
                3'b001:  r.par[0]  = ~p[0];
                3'b010:  r.par[1]  = ~p[1];
                3'b100:  r.par[2]  = ~p[2];
                default: r.fixed   = 1'b0;
            endcase
        end
`ifdef HAMMING_SECDED_EN
        else if ((syn == 3'b000) && ovr) begin
            // Only the overall bit itself is wrong.
            r.par[3] = ~p[3];
            r.fixed  = 1'b1;
        end else if ((syn != 3'b000) && !ovr) begin
            // Even number of flips: detectable but not locatable.
            r.uncorr = 1'b1;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/hamming_block_codec.sv
// -----------------------------------------------------------------------------
// hamming_block_codec
// Combinational encode / syndrome / correction for one 4-bit block.
//   data, par      : current stored data nibble and its stored parity
//   syn_reg,ovr_reg: syndrome and overall mismatch captured during CHECK
//   enc_par        : freshly encoded parity of data
//   syndrome       : stored ^ re-encoded parity (3 bits)
//   overall_mm     : overall parity mismatch (|syndrome in the 3-bit code)
//   fix_data/par   : block contents after applying the captured correction
//   uncorr         : (HAMMING_SECDED_EN only) block holds a double error
//   fixed          : captured correction changes this block
// -----------------------------------------------------------------------------
module hamming_block_codec
    import hamming_pkg::*;
(
    input  logic [BLOCK_DATA_W-1:0] data,
    input  logic [BLOCK_PAR_W-1:0]  par,
    input  logic [2:0]              syn_reg,
    input  logic                    ovr_reg,
    output logic [BLOCK_PAR_W-1:0]  enc_par,
    output logic [2:0]              syndrome,
    output logic                    overall_mm,
    output logic [BLOCK_DATA_W-1:0] fix_data,
    output logic [BLOCK_PAR_W-1:0]  fix_par,
`ifdef HAMMING_SECDED_EN
    output logic                    uncorr,
`endif
    output logic                    fixed
);

    blk_fix_t fix;

    assign enc_par  = enc_block(data);
    assign syndrome = par[2:0] ^ enc_par[2:0];

`ifdef HAMMING_SECDED_EN
    // A consistent codeword has even parity over all eight bits.
    assign overall_mm = ^{data, par};
`else
    assign overall_mm = |syndrome;
`endif

    // Correction uses the registered CHECK result; the block contents cannot
    // change between CHECK and CORRECT because injection is IDLE-only.
    assign fix      = correct_block(data, par, syn_reg, ovr_reg);
    assign fix_data = fix.data;
    assign fix_par  = fix.par;
    assign fixed    = fix.fixed;
`ifdef HAMMING_SECDED_EN
    assign uncorr   = fix.uncorr;
`endif

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_scrub_ctrl
// Owns a Hamming-protected counter and serialises increments, periodic
// scrubs, single-bit correction write-back and debug error injection.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   inc_req/inc_ack  : increment request (held) / one-cycle accept pulse
//   scrub_req        : force a scrub (remembered until the scrub starts)
//   inj_en, inj_*    : XOR masks applied to count/parity while IDLE
//   count, parity    : protected counter and its stored parity
//   busy             : FSM not in IDLE
//   err_corrected    : one-cycle pulse when a correction is written
//   err_block        : corrected-block mask, valid with err_corrected
//   corr_count       : saturating number of corrections
//   uncorr_err       : uncorrectable-error pulse (0 unless SECDED)
// Optional feature macro: HAMMING_SECDED_EN (4-bit-per-block SECDED code).
// -----------------------------------------------------------------------------
module hamming_scrub_ctrl
    import hamming_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int BLOCKS       = WIDTH / 4,
    parameter int PAR_BITS     = BLOCKS * BLOCK_PAR_W,
    parameter int SCRUB_PERIOD = 64,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_req,
    output logic                inc_ack,
    input  logic                scrub_req,
    input  logic                inj_en,
    input  logic [WIDTH-1:0]    inj_data_mask,
    input  logic [PAR_BITS-1:0] inj_par_mask,
    output logic [WIDTH-1:0]    count,
    output logic [PAR_BITS-1:0] parity,
    output logic                busy,
    output logic                err_corrected,
    output logic [BLOCKS-1:0]   err_block,
    output logic [CNT_W-1:0]    corr_count,
    output logic                uncorr_err
);

    localparam int              TMR_W      = $clog2(SCRUB_PERIOD);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCRUB_PERIOD - 1);

    state_t              state_reg,      state_next;
    logic [WIDTH-1:0]    count_reg,      count_next;
    logic [PAR_BITS-1:0] parity_reg,     parity_next;
    logic [TMR_W-1:0]    timer_reg,      timer_next;
    logic                pending_reg,    pending_next;
    logic [BLOCKS*3-1:0] syn_reg,        syn_next;
    logic [BLOCKS-1:0]   ovr_reg,        ovr_next;
    logic [CNT_W-1:0]    corr_count_reg, corr_count_next;

    // Per-block codec outputs, concatenated in block order.
    logic [PAR_BITS-1:0] enc_all;
    logic [BLOCKS*3-1:0] syn_all;
    logic [BLOCKS-1:0]   ovr_all;
    logic [WIDTH-1:0]    fix_count;
    logic [PAR_BITS-1:0] fix_parity;
    logic [BLOCKS-1:0]   fix_mask;
`ifdef HAMMING_SECDED_EN
    logic [BLOCKS-1:0]   uncorr_mask;
`endif

    for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_blk
        hamming_block_codec u_codec (
            .data       (count_reg[gi*BLOCK_DATA_W +: BLOCK_DATA_W]),
            .par        (parity_reg[gi*BLOCK_PAR_W +: BLOCK_PAR_W]),
            .syn_reg    (syn_reg[gi*3 +: 3]),
            .ovr_reg    (ovr_reg[gi]),
            .enc_par    (enc_all[gi*BLOCK_PAR_W +: BLOCK_PAR_W]),
            .syndrome   (syn_all[gi*3 +: 3]),
            .overall_mm (ovr_all[gi]),
            .fix_data   (fix_count[gi*BLOCK_DATA_W +: BLOCK_DATA_W]),
            .fix_par    (fix_parity[gi*BLOCK_PAR_W +: BLOCK_PAR_W]),
`ifdef HAMMING_SECDED_EN
            .uncorr     (uncorr_mask[gi]),
`endif
            .fixed      (fix_mask[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            parity_reg     <= '0;
            timer_reg      <= TMR_RELOAD;
            pending_reg    <= 1'b0;
            syn_reg        <= '0;
            ovr_reg        <= '0;
            corr_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            parity_reg     <= parity_next;
            timer_reg      <= timer_next;
            pending_reg    <= pending_next;
            syn_reg        <= syn_next;
            ovr_reg        <= ovr_next;
            corr_count_reg <= corr_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        parity_next     = parity_reg;
        syn_next        = syn_reg;
        ovr_next        = ovr_reg;
        corr_count_next = corr_count_reg;
        timer_next      = (timer_reg != '0) ? timer_reg - 1'b1 : '0;
        pending_next    = pending_reg | scrub_req;

        case (state_reg)
            IDLE: begin
                if (inj_en) begin
                    count_next  = count_reg ^ inj_data_mask;
                    parity_next = parity_reg ^ inj_par_mask;
                end else if ((timer_reg == '0) || pending_reg || scrub_req) begin
                    state_next = CHECK;
                end else if (inc_req) begin
                    state_next = INCR;
                end
            end
            INCR: begin
                count_next = count_reg + 1'b1;
                state_next = ENCODE;
            end
            ENCODE: begin
                parity_next = enc_all;
                state_next  = IDLE;
            end
            CHECK: begin
                syn_next     = syn_all;
                ovr_next     = ovr_all;
                timer_next   = TMR_RELOAD;
                // Clearing here also swallows a scrub_req seen this cycle.
                pending_next = 1'b0;
                state_next   = ((|syn_all) || (|ovr_all)) ? CORRECT : IDLE;
            end
            CORRECT: begin
                count_next  = fix_count;
                parity_next = fix_parity;
                // Blocks flagged only as uncorrectable do not count.
                if ((|fix_mask) && (corr_count_reg != {CNT_W{1'b1}})) begin
                    corr_count_next = corr_count_reg + 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign inc_ack       = (state_reg == INCR);
    assign busy          = (state_reg != IDLE);
    assign err_corrected = (state_reg == CORRECT) && (|fix_mask);
    assign err_block     = (state_reg == CORRECT) ? fix_mask : '0;
    assign count         = count_reg;
    assign parity        = parity_reg;
    assign corr_count    = corr_count_reg;
`ifdef HAMMING_SECDED_EN
    assign uncorr_err    = (state_reg == CORRECT) && (|uncorr_mask);
`else
    assign uncorr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hamming_scrub_ctrl
// Directed and randomized checks of hamming_scrub_ctrl against a reference
// model that tracks the intended counter value; parity is recomputed from the
// block equations, and a correction is expected to restore the clean value.
// Honours HAMMING_SECDED_EN.
// -----------------------------------------------------------------------------
module tb_hamming_scrub_ctrl;

    localparam int WIDTH  = 16;
    localparam int BLOCKS = WIDTH / 4;
    localparam int CNT_W  = 8;
`ifdef HAMMING_SECDED_EN
    localparam int BPW = 4;
`else
    localparam int BPW = 3;
`endif
    localparam int PAR_BITS = BLOCKS * BPW;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                inc_req = 1'b0;
    logic                inc_ack;
    logic                scrub_req = 1'b0;
    logic                inj_en = 1'b0;
    logic [WIDTH-1:0]    inj_data_mask = '0;
    logic [PAR_BITS-1:0] inj_par_mask = '0;
    logic [WIDTH-1:0]    count;
    logic [PAR_BITS-1:0] parity;
    logic                busy;
    logic                err_corrected;
    logic [BLOCKS-1:0]   err_block;
    logic [CNT_W-1:0]    corr_count;
    logic                uncorr_err;

    hamming_scrub_ctrl #(
        .WIDTH(WIDTH), .SCRUB_PERIOD(64), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inc_req(inc_req), .inc_ack(inc_ack),
        .scrub_req(scrub_req),
        .inj_en(inj_en), .inj_data_mask(inj_data_mask), .inj_par_mask(inj_par_mask),
        .count(count), .parity(parity), .busy(busy),
        .err_corrected(err_corrected), .err_block(err_block),
        .corr_count(corr_count), .uncorr_err(uncorr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [WIDTH-1:0] m_count;
    int               m_corr;

    // Scrub observations
    int                s_corr, s_unc, s_busy;
    logic [BLOCKS-1:0] s_blk, s_stray;

    function automatic logic [PAR_BITS-1:0] model_enc(input logic [WIDTH-1:0] c);
        logic [PAR_BITS-1:0] p;
        logic [3:0] d;
        p = '0;
        for (int b = 0; b < BLOCKS; b++) begin
            d = c[b*4 +: 4];
            p[b*BPW+0] = d[0] ^ d[1] ^ d[2];
            p[b*BPW+1] = d[0] ^ d[1] ^ d[3];
            p[b*BPW+2] = d[0] ^ d[2] ^ d[3];
`ifdef HAMMING_SECDED_EN
            p[b*BPW+3] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ p[b*BPW+0] ^ p[b*BPW+1] ^ p[b*BPW+2];
`endif
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        inc_req = 1'b0; scrub_req = 1'b0; inj_en = 1'b0;
        inj_data_mask = '0; inj_par_mask = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_count = '0;
        m_corr  = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_parity"}, 32'(parity), 32'(model_enc(m_count)));
        check({tag, "_corr_count"}, 32'(corr_count), 32'(m_corr));
    endtask

    // Full increment handshake; also checks the 1-cycle ack and 2 busy cycles.
    task automatic do_inc(input string tag);
        int n;
        inc_req = 1'b1;
        n = 0;
        while (!inc_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, 32'(inc_ack), 32'd1);
        inc_req = 1'b0;
        m_count = m_count + 1'b1;
        n = 0;
        do begin
            n++;
            @(negedge clk);
            if (n == 1) check({tag, "_ack_pulse"}, 32'(inc_ack), 32'd0);
        end while (busy && n < 10);
        check({tag, "_busy_cycles"}, 32'(n), 32'd2);
        check_state(tag);
        $display("inc   %-12s count=%h parity=%h", tag, count, parity);
    endtask

    task automatic do_inject(input logic [WIDTH-1:0] dm, input logic [PAR_BITS-1:0] pm);
        wait_idle("inject_wait_idle");
        inj_en = 1'b1; inj_data_mask = dm; inj_par_mask = pm;
        @(negedge clk);
        inj_en = 1'b0; inj_data_mask = '0; inj_par_mask = '0;
        $display("inj   data_mask=%h par_mask=%h count=%h parity=%h", dm, pm, count, parity);
    endtask

    task automatic do_scrub(input string tag);
        int n;
        s_corr = 0; s_unc = 0; s_busy = 0; s_blk = '0; s_stray = '0;
        scrub_req = 1'b1;
        @(negedge clk);
        scrub_req = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            s_busy++;
            if (err_corrected) begin
                s_corr++;
                s_blk = err_block;
            end else begin
                s_stray = s_stray | err_block;
            end
            if (uncorr_err) s_unc++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        check({tag, "_err_block_idle"}, 32'(s_stray), 32'd0);
        $display("scrub %-12s corr=%0d blk=%b unc=%0d busy=%0d count=%h parity=%h",
                 tag, s_corr, s_blk, s_unc, s_busy, count, parity);
    endtask

    initial begin
        int n;
        int b, k;
        logic [WIDTH-1:0]    dm;
        logic [PAR_BITS-1:0] pm;

        // ---- reset values ----
        do_reset();
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({inc_ack, err_corrected, uncorr_err}), 32'd0);
        check("rst_err_block", 32'(err_block), 32'd0);
        check("rst_corr_count", 32'(corr_count), 32'd0);

        // ---- five increments ----
        for (int i = 0; i < 5; i++) do_inc("five_inc");
        check("five_count", 32'(count), 32'h5);
`ifndef HAMMING_SECDED_EN
        check("five_parity", 32'(parity), 32'h002);
`endif

        // ---- single data-bit error in block 0 ----
        do_inject(16'h0004, '0);
        check("inj_data_applied", 32'(count), 32'h1);
        do_scrub("data_err");
        m_corr++;
        check("data_err_pulses", 32'(s_corr), 32'd1);
        check("data_err_block", 32'(s_blk), 32'b0001);
        check_state("data_err");

        // ---- single parity-bit error in block 1 (p0) ----
        pm = '0; pm[BPW] = 1'b1;
        do_inject('0, pm);
        do_scrub("par_err");
        m_corr++;
        check("par_err_pulses", 32'(s_corr), 32'd1);
        check("par_err_block", 32'(s_blk), 32'b0010);
        check_state("par_err");

        // ---- wrap 0xFFFF -> 0 ----
        do_reset();
        do_inject('1, '1);
        m_count = '1;
        do_inc("wrap");
        check("wrap_count", 32'(count), 32'h0);
        check("wrap_parity", 32'(parity), 32'h0);
        do_scrub("wrap_clean");
        check("wrap_clean_pulses", 32'(s_corr + s_unc), 32'd0);
        check("wrap_clean_busy", 32'(s_busy), 32'd1);

        // ---- automatic scrub timing ----
        do_reset();
        n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timer_first_check", 32'(n), 32'd64);
        n = 0;
        while (busy && n < 20) begin
            if (err_corrected) check("timer_no_corr", 32'(err_corrected), 32'd0);
            @(negedge clk);
            n++;
        end
        check("timer_busy_len", 32'(n), 32'd1);
        $display("timer check reached, busy length %0d", n);

        // ---- inc_req and scrub_req together: scrub goes first ----
        do_reset();
        @(negedge clk);
        inc_req = 1'b1; scrub_req = 1'b1;
        @(negedge clk);
        scrub_req = 1'b0;
        check("conc_busy_first", 32'(busy), 32'd1);
        check("conc_no_ack_first", 32'(inc_ack), 32'd0);
        do_inc("conc");

        // ---- reset while an increment is in flight ----
        do_reset();
        inc_req = 1'b1;
        n = 0;
        while (!inc_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_in_incr", 32'(inc_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_count = '0;
        m_corr  = 0;
        do_inc("midrst_after");

`ifdef HAMMING_SECDED_EN
        // ---- double error: detected, not corrected ----
        do_reset();
        for (int i = 0; i < 5; i++) do_inc("secded_pre");
        do_inject(16'h0003, '0);
        do_scrub("double_err");
        check("double_unc", 32'(s_unc), 32'd1);
        check("double_corr", 32'(s_corr), 32'd0);
        check("double_count", 32'(count), 32'h6);
        check("double_corr_count", 32'(corr_count), 32'd0);
        m_count = 16'h6;
        do_inc("double_clean");
`endif

        // ---- randomized increments and single-bit errors ----
        do_reset();
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) != 2) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) do_inc("rnd_inc");
            end else begin
                b = $urandom_range(0, BLOCKS - 1);
                k = $urandom_range(0, BPW + 3);
                dm = '0; pm = '0;
                if (k < 4) dm[b*4 + k] = 1'b1;
                else       pm[b*BPW + k - 4] = 1'b1;
                do_inject(dm, pm);
                do_scrub("rnd_err");
                m_corr++;
                check("rnd_err_pulses", 32'(s_corr), 32'd1);
                check("rnd_err_block", 32'(s_blk), 32'(1 << b));
                check_state("rnd_err");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
